dtree_frame_sequencer: RTL and testbench



---
 rtl/dtree_seq_pkg.sv | 14 +
 rtl/dtree_frame_sequencer_if.sv | 24 ++
 rtl/dtree_feat_bank.sv | 33 +++
 rtl/dtree_frame_sequencer.sv | 140 ++++++++++++++
 tb/tb_dtree_frame_sequencer.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/dtree_seq_pkg.sv
// Shared types and constants for the decision-tree frame sequencer.
package dtree_seq_pkg;

  typedef enum logic [1:0] {LOAD, DRAIN, SETTLE, RESULT} state_e;

  localparam int DEF_FEAT_W  = 8;
  localparam int DEF_CLASS_W = 2;
  localparam int CNT_W       = 16;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/dtree_frame_sequencer_if.sv
// Feature-stream and result handshakes of the frame sequencer; the sequencer is the slave.
interface dtree_frame_sequencer_if #(
  parameter int FEAT_W  = 8,
  parameter int CLASS_W = 2
);
  logic               feat_valid;
  logic               feat_ready;
  logic [FEAT_W-1:0]  feat_data;
  logic               feat_last;
  logic               res_valid;
  logic               res_ready;
  logic [CLASS_W-1:0] res_class;
  logic               err_len;

  modport master (
    output feat_valid, feat_data, feat_last, res_ready,
    input  feat_ready, res_valid, res_class, err_len
  );

  modport slave (
    input  feat_valid, feat_data, feat_last, res_ready,
    output feat_ready, res_valid, res_class, err_len
  );
endinterface

// File: rtl/dtree_feat_bank.sv
// Registered feature bank: one FEAT_W slot per feature, written by index, presented flat.
module dtree_feat_bank #(
  parameter int N_FEAT = 20,
  parameter int FEAT_W = 8,
  parameter int IDX_W  = $clog2(N_FEAT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [IDX_W-1:0]         idx,
  input  logic [FEAT_W-1:0]        wdata,
  output logic [N_FEAT*FEAT_W-1:0] feat_vec
);

  logic [N_FEAT*FEAT_W-1:0] vec_q, vec_d;

  // NOTE: start from the held value so every path assigns vec_d and no latch is inferred.
  always_comb begin
    vec_d = vec_q;
    if (we) vec_d[int'(idx)*FEAT_W +: FEAT_W] = wdata;
  end

  // NOTE: the bank is reset even though it is storage: the tree sees it directly, so a
  // known all-zero vector after reset is part of the interface, not a nicety.
  // NOTE: non-blocking assignment for every flop so all state updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) vec_q <= '0;
    else     vec_q <= vec_d;
  end

  assign feat_vec = vec_q;

endmodule

// File: rtl/dtree_frame_sequencer.sv
// Loads a feature frame, freezes it for SETTLE_CYC cycles in front of the tree, returns the class.
// Build option DTREE_CLASS_CNT_EN adds saturating per-class result counters on cls_cnt.
module dtree_frame_sequencer
  import dtree_seq_pkg::*;
#(
  parameter int N_FEAT     = 20,
  parameter int FEAT_W     = DEF_FEAT_W,
  parameter int CLASS_W    = DEF_CLASS_W,
  parameter int SETTLE_CYC = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  dtree_frame_sequencer_if.slave   bus,
  output logic [N_FEAT*FEAT_W-1:0] feat_vec,
  input  logic [CLASS_W-1:0]       tree_class
`ifdef DTREE_CLASS_CNT_EN
  ,
  output logic [(2**CLASS_W)*CNT_W-1:0] cls_cnt
`endif
);

  localparam int               IDX_W       = $clog2(N_FEAT);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_FEAT - 1);
  localparam logic [3:0]       SETTLE_INIT = 4'(SETTLE_CYC - 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               res_valid_q, res_valid_d;
  logic [CLASS_W-1:0] res_class_q, res_class_d;
  logic               err_len_q, err_len_d;
  logic               beat, res_hs, bank_we;

  assign bus.feat_ready = (state_q == LOAD) || (state_q == DRAIN);
  assign beat           = bus.feat_valid && bus.feat_ready;
  assign res_hs         = res_valid_q && bus.res_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_class_d = res_class_q;
    err_len_d   = 1'b0;
    bank_we     = 1'b0;
    unique case (state_q)
      LOAD: if (beat) begin
        bank_we = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (bus.feat_last) begin
            cnt_d   = SETTLE_INIT;
            state_d = SETTLE;
          end else begin
            err_len_d = 1'b1;
            state_d   = DRAIN;
          end
        end else if (bus.feat_last) begin
          // Short frame: partial slots are left as they are for the next frame to overwrite.
          err_len_d = 1'b1;
          idx_d     = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DRAIN: if (beat && bus.feat_last) begin
        idx_d   = '0;
        state_d = LOAD;
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          res_class_d = tree_class;
          res_valid_d = 1'b1;
          state_d     = RESULT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESULT: if (res_hs) begin
        res_valid_d = 1'b0;
        state_d     = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_class_q <= '0;
      err_len_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_class_q <= res_class_d;
      err_len_q   <= err_len_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_class = res_class_q;
  assign bus.err_len   = err_len_q;

  dtree_feat_bank #(
    .N_FEAT (N_FEAT),
    .FEAT_W (FEAT_W),
    .IDX_W  (IDX_W)
  ) u_bank (
    .clk      (clk),
    .rst      (rst),
    .we       (bank_we),
    .idx      (idx_q),
    .wdata    (bus.feat_data),
    .feat_vec (feat_vec)
  );

`ifdef DTREE_CLASS_CNT_EN
  logic [(2**CLASS_W)*CNT_W-1:0] cls_cnt_q, cls_cnt_d;

  always_comb begin
    cls_cnt_d = cls_cnt_q;
    if (res_hs)
      cls_cnt_d[int'(res_class_q)*CNT_W +: CNT_W] =
        sat_inc(cls_cnt_q[int'(res_class_q)*CNT_W +: CNT_W]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cls_cnt_q <= '0;
    else     cls_cnt_q <= cls_cnt_d;
  end

  assign cls_cnt = cls_cnt_q;
`endif

endmodule

// File: tb/tb_dtree_frame_sequencer.sv
// Directed bench for dtree_frame_sequencer: scoreboarded results, length errors, reset mid-frame.
// Define DTREE_CLASS_CNT_EN for both RTL and bench to cover the class counters.
`timescale 1ns/1ps
module tb_dtree_frame_sequencer;
  import dtree_seq_pkg::*;

  localparam int N_FEAT     = 20;
  localparam int FEAT_W     = 8;
  localparam int CLASS_W    = 2;
  localparam int SETTLE_CYC = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dtree_frame_sequencer_if #(.FEAT_W(FEAT_W), .CLASS_W(CLASS_W)) bus ();
  logic [N_FEAT*FEAT_W-1:0] feat_vec;
  logic [CLASS_W-1:0]       tree_class;
`ifdef DTREE_CLASS_CNT_EN
  logic [(2**CLASS_W)*CNT_W-1:0] cls_cnt;
`endif

  // Stand-in printed tree: class = low bits of slot 0 xor low bits of slot 19.
  assign tree_class = feat_vec[1:0] ^ feat_vec[19*FEAT_W +: 2];

  dtree_frame_sequencer #(
    .N_FEAT(N_FEAT), .FEAT_W(FEAT_W), .CLASS_W(CLASS_W), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .feat_vec   (feat_vec),
    .tree_class (tree_class)
`ifdef DTREE_CLASS_CNT_EN
    ,
    .cls_cnt    (cls_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;
  int res_hs = 0;
  int err_cnt = 0;
  int exp_tally [4];
  logic [7:0] frm [32];
  logic [CLASS_W-1:0] exp_q [$];

  always @(posedge clk) begin
    if (bus.res_valid && bus.res_ready) res_hs++;
    if (bus.err_len) err_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FEAT_W-1:0] slot(input int k);
    return feat_vec[k*FEAT_W +: FEAT_W];
  endfunction

  function automatic logic [CLASS_W-1:0] tree_model();
    return frm[0][1:0] ^ frm[19][1:0];
  endfunction

  // Presents one beat, waits (bounded) for feat_ready, returns 1 ns after the accepting edge.
  task automatic send_beat(input logic [7:0] d, input logic last);
    int n = 0;
    bus.feat_valid = 1'b1;
    bus.feat_data  = d;
    bus.feat_last  = last;
    while (bus.feat_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("beat_ready", bus.feat_ready, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int len, input int last_pos, input bit push);
    for (int i = 0; i < len; i++) send_beat(frm[i], i == last_pos);
    bus.feat_valid = 1'b0;
    bus.feat_last  = 1'b0;
    if (push) exp_q.push_back(tree_model());
  endtask

  // Latency counts the last-beat cycle as cycle 0; the first negedge after it is cycle 1.
  task automatic wait_result(input string tag, input int hold, input bit chk_lat);
    int lat = 0;
    bit stable = 1'b1;
    logic [CLASS_W-1:0] exp;
    do begin
      @(negedge clk);
      lat++;
    end while (bus.res_valid !== 1'b1 && lat < 100);
    check({tag, "_valid"}, bus.res_valid, 1);
    if (chk_lat) check({tag, "_latency"}, lat, SETTLE_CYC + 1);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check({tag, "_class"}, bus.res_class, exp);
    for (int i = 0; i < hold; i++) begin
      if (!(bus.res_valid === 1'b1 && bus.res_class === exp && bus.feat_ready === 1'b0))
        stable = 1'b0;
      @(negedge clk);
    end
    if (hold > 0) check({tag, "_hold"}, stable, 1);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_drop"}, bus.res_valid, 0);
    check({tag, "_ready_back"}, bus.feat_ready, 1);
    if (!$isunknown(exp)) exp_tally[exp]++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hs0, err0;
    logic [7:0] b0;
    foreach (exp_tally[i]) exp_tally[i] = 0;
    rst = 1'b1;
    bus.feat_valid = 1'b0;
    bus.feat_data  = '0;
    bus.feat_last  = 1'b0;
    bus.res_ready  = 1'b1;
    #12;
    check("rst_feat_ready", bus.feat_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_class", bus.res_class, 0);
    check("rst_err_len", bus.err_len, 0);
    check("rst_feat_vec_zero", feat_vec == '0, 1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Frame A: 0x00..0x13, consumer always ready.
    for (int i = 0; i < N_FEAT; i++) frm[i] = 8'(i);
    send_frame(N_FEAT, N_FEAT - 1, 1);
    check("a_slot7", slot(7), frm[7]);
    check("a_settle_not_ready", bus.feat_ready, 0);
    wait_result("a", 0, 1);

    // Frame B held for 10 cycles; frame C's first beat is offered while the sequencer is busy.
    for (int i = 0; i < N_FEAT; i++) frm[i] = 8'(i * 3 + 1);
    b0 = frm[0];
    bus.res_ready = 1'b0;
    send_frame(N_FEAT, N_FEAT - 1, 1);
    for (int i = 0; i < N_FEAT; i++) frm[i] = 8'(8'hF0 - i);
    bus.feat_valid = 1'b1;
    bus.feat_data  = frm[0];
    wait_result("b", 10, 1);
    check("b_slot0_frozen", slot(0), b0);
    send_frame(N_FEAT, N_FEAT - 1, 1);
    check("c_slot0", slot(0), frm[0]);
    wait_result("c", 0, 1);

    // Short frame: last on beat 5.
    for (int i = 0; i < N_FEAT; i++) frm[i] = 8'($urandom);
    hs0 = res_hs;
    err0 = err_cnt;
    send_frame(6, 5, 0);
    check("short_err_pulse", bus.err_len, 1);
    @(posedge clk);
    #1;
    check("short_err_clear", bus.err_len, 0);
    check("short_slot5_kept", slot(5), frm[5]);
    repeat (8) @(negedge clk);
    check("short_no_result", res_hs, hs0);
    check("short_err_count", err_cnt, err0 + 1);
    check("short_ready", bus.feat_ready, 1);
    for (int i = 0; i < N_FEAT; i++) frm[i] = 8'($urandom);
    send_frame(N_FEAT, N_FEAT - 1, 1);
    wait_result("d", 0, 1);

    // Long frame: 25 beats, last on beat 24; beats 20..24 must be dropped.
    for (int i = 0; i < 25; i++) frm[i] = 8'($urandom);
    hs0 = res_hs;
    err0 = err_cnt;
    for (int i = 0; i < 25; i++) begin
      send_beat(frm[i], i == 24);
      if (i == 19) check("long_err_pulse", bus.err_len, 1);
    end
    bus.feat_valid = 1'b0;
    bus.feat_last  = 1'b0;
    repeat (8) @(negedge clk);
    check("long_err_count", err_cnt, err0 + 1);
    check("long_slot0_kept", slot(0), frm[0]);
    check("long_slot19", slot(19), frm[19]);
    check("long_no_result", res_hs, hs0);
    check("long_ready", bus.feat_ready, 1);

    // Full frame after the long one, then reset while it settles.
    for (int i = 0; i < N_FEAT; i++) frm[i] = 8'($urandom) | 8'h01;
    send_frame(N_FEAT, N_FEAT - 1, 0);
    check("rs_in_settle", bus.feat_ready, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rs_feat_ready", bus.feat_ready, 1);
    check("rs_res_valid", bus.res_valid, 0);
    check("rs_err_len", bus.err_len, 0);
    check("rs_feat_vec_zero", feat_vec == '0, 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    foreach (exp_tally[i]) exp_tally[i] = 0;
    repeat (8) @(negedge clk);
    check("rs_no_result", res_hs, hs0);

    // Three frames classified 1, 1, 2.
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < N_FEAT; i++) frm[i] = 8'($urandom);
      frm[19][1:0] = 2'b00;
      frm[0][1:0]  = (f < 2) ? 2'd1 : 2'd2;
      send_frame(N_FEAT, N_FEAT - 1, 1);
      wait_result($sformatf("e%0d", f), 0, 0);
    end
    check("e_tally1", exp_tally[1], 2);
`ifdef DTREE_CLASS_CNT_EN
    for (int c = 0; c < 4; c++)
      check($sformatf("cls_cnt%0d", c), cls_cnt[c*CNT_W +: CNT_W], exp_tally[c]);
`endif
    check("final_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
